// File: rtl/mac_pkg.sv
// Shared types for the MAC PE sequencer: operand pair layout, FSM states, widths.
package mac_pkg;

  localparam int W_W    = 4;
  localparam int A_W    = 8;
  localparam int RES_W  = 18;
  localparam int PAIR_W = W_W + A_W;

  // One buffer word: signed weight in the top nibble, signed activation below.
  typedef struct packed {
    logic signed [W_W-1:0] weight;
    logic signed [A_W-1:0] act;
  } pair_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic signed [W_W-1:0] pair_weight(input pair_t p);
    return p.weight;
  endfunction

  function automatic logic signed [A_W-1:0] pair_act(input pair_t p);
    return p.act;
  endfunction

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Operand read address generator: counts issued reads against the job length
// and flags which cycles have read data returning from the buffer.
module mac_seq_addr_gen
  import mac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic              rd_pend
);

  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] len_q;

  assign done  = (rd_cnt == len_q);
  assign rd_en = step & ~done;

  // Load on job start, then advance one address per issued read (wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      rd_cnt  <= '0;
      len_q   <= '0;
      rd_pend <= 1'b0;
    end else if (start) begin
      addr    <= base;
      rd_cnt  <= '0;
      len_q   <= len;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        addr   <= addr + ADDR_W'(1);
        rd_cnt <= rd_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one weight-grouped MAC PE: clear, stream pairs, flush, collect result.
//
//   state  | meaning
//   IDLE   | ready for a job
//   CLEAR  | PE clear, first operand read issued (if len>0)
//   STREAM | one pair per cycle into the PE, next read in flight
//   FLUSH  | PE commits its last group
//   WAIT   | waiting for PE result, bounded by WAIT_MAX cycles
//   RESP   | result held on res_* until res_ready
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 10,
  parameter int WAIT_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_base,
  input  logic [LEN_W-1:0]        cmd_len,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [PAIR_W-1:0]       mem_rdata,
  output logic                    mac_en,
  output logic                    mac_data_valid,
  output logic signed [W_W-1:0]   mac_weight,
  output logic signed [A_W-1:0]   mac_activation,
  output logic                    mac_reset,
  output logic                    mac_acc,
  input  logic                    mac_output_valid,
  input  logic signed [RES_W-1:0] mac_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [RES_W-1:0] res_data,
  output logic [LEN_W-1:0]        res_nnz,
  output logic                    res_err,
  output logic                    busy
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  state_t           state, state_nxt;
  logic             ready_q;
  logic             start, step, done, rd_pend;
  logic             capture, cap_err;
  logic [LEN_W-1:0] str_left;
  logic [LEN_W-1:0] nnz_cnt;
  logic [WC_W-1:0]  wait_cnt;
  pair_t            pair;

  mac_seq_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (cmd_base),
    .len     (cmd_len),
    .step    (step),
    .rd_en   (mem_rd_en),
    .addr    (mem_addr),
    .done    (done),
    .rd_pend (rd_pend)
  );

  assign pair           = pair_t'(mem_rdata);
  assign mac_data_valid = (state == ST_STREAM) & rd_pend;
  assign mac_weight     = mac_data_valid ? pair_weight(pair) : '0;
  assign mac_activation = mac_data_valid ? pair_act(pair) : '0;
  assign res_valid      = (state == ST_RESP);
  assign busy           = (state != ST_IDLE);

  // State register; ready_q keeps cmd_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
    end
  end

  // Next-state and PE phase controls.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mac_en    = 1'b0;
    mac_reset = 1'b0;
    mac_acc   = 1'b0;
    start     = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    cap_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = ready_q;
        if (cmd_valid && ready_q) begin
          start     = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mac_en    = 1'b1;
        mac_reset = 1'b1;
        step      = 1'b1;
        state_nxt = done ? ST_FLUSH : ST_STREAM;
      end
      ST_STREAM: begin
        mac_en = 1'b1;
        step   = 1'b1;
        if (str_left == LEN_W'(1)) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        mac_en    = 1'b1;
        mac_acc   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mac_output_valid) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end else if (wait_cnt == '0) begin
          capture   = 1'b1;
          cap_err   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stream length down-counter, nonzero-pair count and WAIT timeout down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_left <= '0;
      nnz_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (start) begin
        str_left <= cmd_len;
        nnz_cnt  <= '0;
      end else if (state == ST_STREAM) begin
        str_left <= str_left - LEN_W'(1);
        if (mac_data_valid && (pair.weight != '0) && (pair.act != '0))
          nnz_cnt <= nnz_cnt + LEN_W'(1);
      end
      if (state == ST_FLUSH)
        wait_cnt <= WC_W'(WAIT_MAX - 1);
      else if ((state == ST_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - WC_W'(1);
    end
  end

  // Result capture; holds through RESP and beyond until the next job's capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_nnz  <= '0;
      res_err  <= 1'b0;
    end else if (capture) begin
      res_data <= cap_err ? '0 : mac_result;
      res_nnz  <= nnz_cnt;
      res_err  <= cap_err;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural PE and operand buffer.
module tb_mac_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [9:0]         cmd_base = '0;
  logic [9:0]         cmd_len = '0;
  logic               mem_rd_en;
  logic [9:0]         mem_addr;
  logic [11:0]        mem_rdata = '0;
  logic               mac_en, mac_data_valid, mac_reset, mac_acc;
  logic signed [3:0]  mac_weight;
  logic signed [7:0]  mac_activation;
  logic               mac_output_valid;
  logic signed [17:0] mac_result;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic signed [17:0] res_data;
  logic [9:0]         res_nnz;
  logic               res_err;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int rd_total = 0;
  int dv_total = 0;
  int rd0, dv0;
  logic [9:0] last_rd_addr = '0;

  logic [11:0]        mem [0:1023];
  logic               pe_dead = 1'b0;
  logic signed [17:0] pe_acc = '0;
  logic signed [17:0] pe_res = '0;
  logic               pe_ov = 1'b0;

  assign mac_output_valid = pe_ov;
  assign mac_result       = pe_res;

  mac_seq_ctrl #(.ADDR_W(10), .LEN_W(10), .WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mac_en(mac_en), .mac_data_valid(mac_data_valid), .mac_weight(mac_weight),
    .mac_activation(mac_activation), .mac_reset(mac_reset), .mac_acc(mac_acc),
    .mac_output_valid(mac_output_valid), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_nnz(res_nnz), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int w, input int a);
    logic [3:0] wv;
    logic [7:0] av;
    wv = w[3:0];
    av = a[7:0];
    return {wv, av};
  endfunction

  // Operand buffer with one-cycle read latency, plus read/valid bookkeeping.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata    <= mem[mem_addr];
      rd_total     <= rd_total + 1;
      last_rd_addr <= mem_addr;
    end
    if (mac_data_valid) dv_total <= dv_total + 1;
  end

  // Behavioural PE: plain signed dot product, result valid one cycle after flush.
  always @(posedge clk) begin
    pe_ov <= 1'b0;
    if (mac_en) begin
      if (mac_reset) pe_acc <= '0;
      else if (mac_data_valid) pe_acc <= pe_acc + mac_weight * mac_activation;
      else if (mac_acc && !pe_dead) begin
        pe_ov  <= 1'b1;
        pe_res <= pe_acc;
      end
    end
  end

  // PE control strobes must be exclusive, only with mac_en; flush presents zeros.
  always @(negedge clk) begin
    if (rst_n && (mac_reset || mac_acc || mac_data_valid))
      check("ctl_excl", int'(mac_en && ((int'(mac_reset) + int'(mac_acc) + int'(mac_data_valid)) == 1)), 1);
    if (rst_n && mac_acc)
      check("flush_zero", int'(mac_weight) | int'(mac_activation), 0);
  end

  task automatic accept(input string tag, input logic [9:0] base, input logic [9:0] len);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    rd0 = rd_total;
    dv0 = dv_total;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_clr_rd"}, int'(mem_rd_en), int'(len != 0));
    if (len != 0) check({tag, "_addr0"}, int'(mem_addr), int'(base));
  endtask

  task automatic wait_result(input string tag, input int len, input int exp_data,
                             input int exp_nnz, input int exp_err, input int exp_lat);
    int n;
    n = 1;
    while (!res_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, int'(res_data), exp_data);
    check({tag, "_nnz"}, int'(res_nnz), exp_nnz);
    check({tag, "_err"}, int'(res_err), exp_err);
    check({tag, "_nreads"}, rd_total - rd0, len);
    check({tag, "_ndv"}, dv_total - dv0, len);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_drop"}, int'(res_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = pk(2, 3);  mem[10'h011] = pk(2, 5);  mem[10'h012] = pk(-1, 4);
    mem[10'h020] = pk(2, 3);  mem[10'h021] = pk(-2, 5);
    mem[10'h030] = pk(0, 7);  mem[10'h031] = pk(3, 0);
    mem[10'h032] = pk(3, 2);  mem[10'h033] = pk(-8, 1);
    mem[10'h3FF] = pk(3, 2);  mem[10'h000] = pk(1, -1);

    #12;
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_mac_en", int'(mac_en), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", int'(cmd_ready), 1);

    accept("j1", 10'h010, 10'd3);
    wait_result("j1", 3, 12, 3, 0, 7);
    check("j1_last_addr", int'(last_rd_addr), 'h012);
    handshake("j1");

    accept("j2", 10'h020, 10'd2);
    wait_result("j2", 2, -4, 2, 0, 6);
    handshake("j2");

    accept("j3", 10'h030, 10'd4);
    wait_result("j3", 4, -2, 2, 0, 8);
    handshake("j3");

    accept("j0", 10'h040, 10'd0);
    wait_result("j0", 0, 0, 0, 0, 4);
    handshake("j0");

    accept("wrap", 10'h3FF, 10'd2);
    wait_result("wrap", 2, 5, 2, 0, 6);
    check("wrap_last_addr", int'(last_rd_addr), 0);
    handshake("wrap");

    // Backpressure with a second command waiting.
    accept("bp", 10'h010, 10'd3);
    wait_result("bp", 3, 12, 3, 0, 7);
    cmd_valid = 1'b1;
    cmd_base  = 10'h020;
    cmd_len   = 10'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_cmd_ready", int'(cmd_ready), 0);
      check("bp_valid_hold", int'(res_valid), 1);
      check("bp_data_hold", int'(res_data), 12);
      check("bp_nnz_hold", int'(res_nnz), 3);
    end
    res_ready = 1'b1;
    rd0 = rd_total;
    dv0 = dv_total;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_drop", int'(res_valid), 0);
    check("bp_idle_ready", int'(cmd_ready), 1);
    check("bp_res_hold", int'(res_data), 12);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp2_accepted", int'(busy), 1);
    wait_result("bp2", 2, -4, 2, 0, 6);
    handshake("bp2");

    // PE never reports: forced result with error after the WAIT timeout.
    pe_dead = 1'b1;
    accept("err", 10'h010, 10'd1);
    wait_result("err", 1, 0, 1, 1, 8);
    handshake("err");
    pe_dead = 1'b0;

    // Asynchronous reset in the middle of streaming.
    accept("rst", 10'h030, 10'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_stream", int'(mac_data_valid), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_mac_en", int'(mac_en), 0);
    check("arst_rd_en", int'(mem_rd_en), 0);
    check("arst_ready", int'(cmd_ready), 0);
    check("arst_res_err", int'(res_err), 0);
    check("arst_res_valid", int'(res_valid), 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept("post", 10'h030, 10'd4);
    wait_result("post", 4, -2, 2, 0, 8);
    handshake("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
